// File: rtl/vram_port_arbiter_if.sv
// Bundles the CPU posted-write, render read and memory macro signals of the VRAM port arbiter.
// Latency: none, wiring only.
// Backpressure: the CPU side sees o_cpu_full; the render side holds i_rd_req until o_rd_grant.
interface vram_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 3
);
    // CPU posted-write path
    logic              i_cpu_we;
    logic [ADDR_W-1:0] i_cpu_addr;
    logic [DATA_W-1:0] i_cpu_wdata;
    logic              o_cpu_full;
    logic              o_cpu_overflow;
    logic [CNT_W-1:0]  o_fifo_count;

    // Render read port
    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              o_rd_grant;
    logic              o_rd_valid;
    logic [DATA_W-1:0] o_rd_data;

    // Single-port memory macro
    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    // Arbiter side
    modport slave (
        input  i_cpu_we, i_cpu_addr, i_cpu_wdata,
        output o_cpu_full, o_cpu_overflow, o_fifo_count,
        input  i_rd_req, i_rd_addr,
        output o_rd_grant, o_rd_valid, o_rd_data,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata
    );

    // Requester / memory side
    modport master (
        output i_cpu_we, i_cpu_addr, i_cpu_wdata,
        input  o_cpu_full, o_cpu_overflow, o_fifo_count,
        output i_rd_req, i_rd_addr,
        input  o_rd_grant, o_rd_valid, o_rd_data,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rdata
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares one single-port VRAM between render reads and posted CPU writes (write FIFO).
// Latency: memory op issued the same cycle as grant; read data valid one cycle after grant.
// Backpressure: render reads wait on o_rd_grant; CPU pushes are dropped (sticky overflow) while full.
module vram_port_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input logic               clk,
    input logic               reset_n,
    vram_port_arbiter_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    wr_entry_t         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [WAIT_W-1:0] wait_cnt;
    logic              overflow;
    logic              rd_vld;
    logic [DATA_W-1:0] rd_hold;

    logic              fifo_empty;
    logic              fifo_full;
    logic              hazard;
    logic              grant_w;
    logic              grant_r;
    logic              push;
    wr_entry_t         head;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign head       = fifo_mem[rd_ptr];

    // Coherence hazard: the pending read address matches any live FIFO entry.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ((CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count) &&
                (fifo_mem[i].addr == bus.i_rd_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    // Writes take the port when reads are absent, the FIFO is full, the wait bound
    // is reached, or a read would bypass an older write to the same word. Grants
    // are masked during reset so a read launched then never returns data.
    assign grant_w = reset_n && !fifo_empty &&
                     (!bus.i_rd_req || fifo_full ||
                      (wait_cnt == WAIT_W'(MAX_WAIT)) || hazard);
    assign grant_r = reset_n && bus.i_rd_req && !grant_w;
    assign push    = bus.i_cpu_we && !fifo_full;

    assign bus.o_rd_grant     = grant_r;
    assign bus.o_mem_en       = grant_w || grant_r;
    assign bus.o_mem_we       = grant_w;
    assign bus.o_mem_addr     = grant_w ? head.addr : bus.i_rd_addr;
    assign bus.o_mem_wdata    = head.data;
    assign bus.o_cpu_full     = fifo_full;
    assign bus.o_cpu_overflow = overflow;
    assign bus.o_fifo_count   = count;
    assign bus.o_rd_valid     = rd_vld;
    // The macro returns data one cycle after the grant, so the valid cycle passes it
    // straight through; the hold register keeps it stable until the next valid.
    assign bus.o_rd_data      = rd_vld ? bus.i_mem_rdata : rd_hold;

    // FIFO payload storage; only entries inside [rd_ptr, rd_ptr+count) are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: bus.i_cpu_addr, data: bus.i_cpu_wdata};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (grant_w) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, grant_w})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Starvation counter: cycles a non-empty FIFO has been denied, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (fifo_empty || grant_w) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Sticky overflow: any push attempt against a full FIFO, even if it drains this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (bus.i_cpu_we && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // Read return tracking: one valid per grant, data held between valids.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld  <= 1'b0;
            rd_hold <= '0;
        end else begin
            rd_vld <= grant_r;
            if (rd_vld) begin
                rd_hold <= bus.i_mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter with a behavioural single-port memory.
// Latency: expects read data one cycle after each grant; writes in FIFO order.
// Backpressure: exercises read hogging, forced writes, full FIFO and dropped pushes.
module tb_vram_port_arbiter;
    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_WAIT   = 8;
    localparam int CNT_W      = 3;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    wr_t               wr_q [$];
    logic [DATA_W-1:0] rd_q [$];

    // Reference view of memory as the CPU sees it (updated when a push is made).
    logic [DATA_W-1:0] shadow [2048];
    bit                sh_w   [2048];

    // Behavioural memory macro
    logic [DATA_W-1:0] mem [2048];
    bit                mem_w [2048];
    logic [DATA_W-1:0] mem_rdata;

    always #5 clk = ~clk;

    vram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    vram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return 64'hC0DE_0000_0000_0000 | {53'd0, a};
    endfunction

    assign bus.i_mem_rdata = mem_rdata;

    always @(posedge clk) begin
        if (bus.o_mem_en) begin
            if (bus.o_mem_we) begin
                mem[bus.o_mem_addr]   <= bus.o_mem_wdata;
                mem_w[bus.o_mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= mem_w[bus.o_mem_addr] ? mem[bus.o_mem_addr] : pat(bus.o_mem_addr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input bit accept);
        bus.i_cpu_we    = 1'b1;
        bus.i_cpu_addr  = a;
        bus.i_cpu_wdata = d;
        if (accept) begin
            wr_q.push_back('{a: a, d: d});
            shadow[a] = d;
            sh_w[a]   = 1'b1;
        end
    endtask

    // Scoreboard: checks memory writes against pushed writes and read data against
    // the reference view captured at grant time.
    task automatic monitor;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.o_mem_en && bus.o_mem_we) begin
                    n_vec++;
                    if (wr_q.size() == 0) begin
                        n_err++;
                        $display("FAIL wr_unexpected: addr=%h data=%h, no write pending",
                                 bus.o_mem_addr, bus.o_mem_wdata);
                    end else begin
                        wr_t w = wr_q.pop_front();
                        if (bus.o_mem_addr !== w.a || bus.o_mem_wdata !== w.d) begin
                            n_err++;
                            $display("FAIL wr_order: got addr=%h data=%h, want addr=%h data=%h",
                                     bus.o_mem_addr, bus.o_mem_wdata, w.a, w.d);
                        end
                    end
                end
                if (bus.o_rd_valid) begin
                    n_vec++;
                    if (rd_q.size() == 0) begin
                        n_err++;
                        $display("FAIL rd_unexpected_valid: data=%h", bus.o_rd_data);
                    end else begin
                        logic [DATA_W-1:0] e = rd_q.pop_front();
                        if (bus.o_rd_data !== e) begin
                            n_err++;
                            $display("FAIL rd_data: got %h, want %h", bus.o_rd_data, e);
                        end
                    end
                end
                if (bus.o_rd_grant) begin
                    rd_q.push_back(sh_w[bus.i_rd_addr] ? shadow[bus.i_rd_addr]
                                                       : pat(bus.i_rd_addr));
                end
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({bus.o_rd_valid, bus.o_cpu_full, bus.o_cpu_overflow, bus.o_rd_grant,
             bus.o_mem_en, bus.o_mem_we} !== 6'b0 || bus.o_fifo_count !== 3'd0 ||
            bus.o_rd_data !== 64'd0) begin
            n_err++;
            $display("FAIL reset_outputs: vld=%b full=%b ovf=%b cnt=%0d grant=%b en=%b we=%b data=%h",
                     bus.o_rd_valid, bus.o_cpu_full, bus.o_cpu_overflow, bus.o_fifo_count,
                     bus.o_rd_grant, bus.o_mem_en, bus.o_mem_we, bus.o_rd_data);
        end
        reset_n = 1'b1;
        tick();
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = 11'h010;
        #1;
        n_vec++;
        if (bus.o_rd_grant !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_grant: grant=%b, want 1", bus.o_rd_grant);
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (bus.o_rd_grant !== 1'b0 || bus.o_mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_grant_mask: grant=%b en=%b, want 0 0",
                     bus.o_rd_grant, bus.o_mem_en);
        end
        tick();
        n_vec++;
        if (bus.o_rd_valid !== 1'b0 || bus.o_rd_data !== 64'd0) begin
            n_err++;
            $display("FAIL reset_mid_read_valid: vld=%b data=%h, want 0 0",
                     bus.o_rd_valid, bus.o_rd_data);
        end
        bus.i_rd_req = 1'b0;
        reset_n = 1'b1;
        tick();
        n_vec++;
        if (bus.o_rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_after_release_valid: vld=%b, want 0", bus.o_rd_valid);
        end
    endtask

    task automatic test_idle_reads;
        for (int i = 1; i <= 4; i++) begin
            bus.i_rd_req  = 1'b1;
            bus.i_rd_addr = ADDR_W'(i);
            #1;
            n_vec++;
            if (bus.o_rd_grant !== 1'b1 || bus.o_mem_we !== 1'b0 ||
                bus.o_mem_addr !== ADDR_W'(i)) begin
                n_err++;
                $display("FAIL idle_read_grant[%0d]: grant=%b we=%b addr=%h",
                         i, bus.o_rd_grant, bus.o_mem_we, bus.o_mem_addr);
            end
            tick();
        end
        bus.i_rd_req = 1'b0;
        tick();
        tick();
        n_vec++;
        if (rd_q.size() != 0) begin
            n_err++;
            $display("FAIL idle_read_returns: %0d reads outstanding, want 0", rd_q.size());
        end
    endtask

    task automatic test_write_drain;
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = 11'h7F0;
        for (int i = 0; i < 3; i++) begin
            drive_push(ADDR_W'(11'h100 + i), 64'h1000 + 64'(i), 1'b1);
            #1;
            n_vec++;
            if (bus.o_mem_we !== 1'b0) begin
                n_err++;
                $display("FAIL drain_fill_we[%0d]: we=%b, want 0", i, bus.o_mem_we);
            end
            tick();
        end
        bus.i_cpu_we = 1'b0;
        bus.i_rd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (bus.o_fifo_count !== CNT_W'(3 - i) || bus.o_mem_we !== 1'b1 ||
                bus.o_mem_addr !== ADDR_W'(11'h100 + i)) begin
                n_err++;
                $display("FAIL drain_step[%0d]: cnt=%0d we=%b addr=%h, want cnt=%0d we=1 addr=%h",
                         i, bus.o_fifo_count, bus.o_mem_we, bus.o_mem_addr, 3 - i, 11'h100 + i);
            end
            tick();
        end
        n_vec++;
        if (bus.o_fifo_count !== 3'd0) begin
            n_err++;
            $display("FAIL drain_empty: cnt=%0d, want 0", bus.o_fifo_count);
        end
        tick();
    endtask

    task automatic test_starvation;
        int  reads = 0;
        bit  wrote = 0;
        drive_push(11'h200, 64'h2222, 1'b1);
        tick();
        bus.i_cpu_we  = 1'b0;
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = 11'h300;
        for (int c = 0; c < 20 && !wrote; c++) begin
            #1;
            if (bus.o_mem_we === 1'b1) wrote = 1;
            else if (bus.o_rd_grant === 1'b1) reads++;
            tick();
        end
        n_vec++;
        if (!wrote || reads != MAX_WAIT) begin
            n_err++;
            $display("FAIL starve_bound: wrote=%0d after %0d reads, want write after %0d",
                     wrote, reads, MAX_WAIT);
        end
        #1;
        n_vec++;
        if (bus.o_rd_grant !== 1'b1) begin
            n_err++;
            $display("FAIL starve_resume: grant=%b, want 1", bus.o_rd_grant);
        end
        tick();
        bus.i_rd_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_coherence;
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = 11'h300;
        drive_push(11'h055, 64'hAA, 1'b1);
        tick();
        bus.i_cpu_we  = 1'b0;
        bus.i_rd_addr = 11'h055;
        #1;
        n_vec++;
        if (bus.o_mem_we !== 1'b1 || bus.o_rd_grant !== 1'b0 || bus.o_mem_addr !== 11'h055) begin
            n_err++;
            $display("FAIL coherence_write_first: we=%b grant=%b addr=%h, want 1 0 055",
                     bus.o_mem_we, bus.o_rd_grant, bus.o_mem_addr);
        end
        tick();
        n_vec++;
        if (bus.o_rd_grant !== 1'b1) begin
            n_err++;
            $display("FAIL coherence_read_next: grant=%b, want 1", bus.o_rd_grant);
        end
        tick();
        bus.i_rd_req = 1'b0;
        tick();
        tick();
        n_vec++;
        if (rd_q.size() != 0) begin
            n_err++;
            $display("FAIL coherence_returns: %0d reads outstanding, want 0", rd_q.size());
        end
    endtask

    task automatic test_full_overflow;
        bus.i_rd_req  = 1'b1;
        bus.i_rd_addr = 11'h300;
        for (int i = 0; i < 4; i++) begin
            drive_push(ADDR_W'(11'h400 + i), 64'hF00 + 64'(i), 1'b1);
            #1;
            n_vec++;
            if (bus.o_mem_we !== 1'b0 || bus.o_cpu_full !== 1'b0) begin
                n_err++;
                $display("FAIL full_fill[%0d]: we=%b full=%b, want 0 0",
                         i, bus.o_mem_we, bus.o_cpu_full);
            end
            tick();
        end
        drive_push(11'h404, 64'hBAD, 1'b0);
        #1;
        n_vec++;
        if (bus.o_cpu_full !== 1'b1 || bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== 11'h400) begin
            n_err++;
            $display("FAIL full_forced_write: full=%b we=%b addr=%h, want 1 1 400",
                     bus.o_cpu_full, bus.o_mem_we, bus.o_mem_addr);
        end
        tick();
        bus.i_cpu_we = 1'b0;
        n_vec++;
        if (bus.o_fifo_count !== 3'd3 || bus.o_cpu_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL full_drop: cnt=%0d ovf=%b, want 3 1",
                     bus.o_fifo_count, bus.o_cpu_overflow);
        end
        bus.i_rd_req = 1'b0;
        for (int c = 0; c < 10 && bus.o_fifo_count !== 3'd0; c++) tick();
        tick();
        n_vec++;
        if (bus.o_fifo_count !== 3'd0 || bus.o_cpu_overflow !== 1'b1 || wr_q.size() != 0) begin
            n_err++;
            $display("FAIL full_drain: cnt=%0d ovf=%b pending_writes=%0d, want 0 1 0",
                     bus.o_fifo_count, bus.o_cpu_overflow, wr_q.size());
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        n_vec++;
        if (bus.o_cpu_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_reset_clear: ovf=%b, want 0", bus.o_cpu_overflow);
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.i_cpu_we    = 1'b0;
        bus.i_cpu_addr  = '0;
        bus.i_cpu_wdata = '0;
        bus.i_rd_req    = 1'b0;
        bus.i_rd_addr   = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_idle_reads();
        test_write_drain();
        test_starvation();
        test_coherence();
        test_full_overflow();
        n_vec++;
        if (wr_q.size() != 0 || rd_q.size() != 0) begin
            n_err++;
            $display("FAIL final_queues: writes=%0d reads=%0d outstanding, want 0 0",
                     wr_q.size(), rd_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
